// File: rtl/stoch_arith_core_if.sv
// Operand/result bundle for stoch_arith_core.
//
// Handshake: start is a request level that the core samples only while idle
// (busy=0). A request accepted on edge k raises busy after edge k. done is a
// single-cycle pulse; result and sat are valid in that cycle and hold until
// the next done. busy is already low in the done cycle, so a start presented
// during done is accepted.
interface stoch_arith_core_if #(
  parameter int W = 9
);
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         sat;

  modport master (output start, mode, a_in, b_in,
                  input  busy, done, result, sat);
  modport slave  (input  start, mode, a_in, b_in,
                  output busy, done, result, sat);
endinterface

// File: rtl/stoch_arith_core.sv
// Stochastic arithmetic engine: converts two latched operands into random
// bit streams with a reseeded 31-bit LFSR, combines them per mode, and
// averages 2^L stream bits into a W-bit result (clamped to all ones when
// every bit was 1).
module stoch_arith_core #(
  parameter int          W    = 9,
  parameter int          L    = 17,
  parameter logic [30:0] SEED = 31'd134995
) (
  input  logic               clk,
  input  logic               rst_n,
  stoch_arith_core_if.slave  bus,
  output logic               o_dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic         w_accept;
  logic         w_finish;
  logic         w_last;

  logic [30:0]  r_lfsr;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [1:0]   r_m;
  logic [L:0]   r_ones;
  logic [L-1:0] r_cnt;
  logic         r_d;
  logic         r_busy;
  logic         r_done;
  logic [W-1:0] r_result;
  logic         r_sat;

  logic         w_sa;
  logic         w_sb;
  logic         w_sel;
  logic         w_bit;
  logic [L:0]   w_ones_next;

  assign w_last      = &r_cnt;
  assign w_sa        = (r_lfsr[W-1:0] < r_a);
  assign w_sb        = (r_lfsr[W+11:12] < r_b);
  assign w_sel       = r_lfsr[30];
  assign w_ones_next = r_ones + {{L{1'b0}}, w_bit};

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign bus.sat     = r_sat;
  assign o_dbg_state = r_state;

  // Stream bit for the current cycle, selected by the latched mode
  always_comb begin
    w_bit = 1'b0;
    case (r_m)
      2'b00:   w_bit = w_sa & w_sb;
      2'b01:   w_bit = ~(w_sa ^ w_sb);
      2'b10:   w_bit = w_sel ? w_sb : w_sa;
      default: w_bit = ~(w_sa ^ r_d);
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next state plus accept/finish strobes for the datapath
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_accept     = 1'b1;
        w_state_next = S_RUN;
      end
      S_RUN: if (w_last) begin
        w_finish     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand latch, stream accumulation, LFSR stepping and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr   <= SEED;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= 2'b00;
      r_ones   <= '0;
      r_cnt    <= '0;
      r_d      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_sat    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // Reseed every run so the stream is reproducible per operand set
        r_a    <= bus.a_in;
        r_b    <= bus.b_in;
        r_m    <= bus.mode;
        r_lfsr <= SEED;
        r_ones <= '0;
        r_cnt  <= '0;
        r_d    <= 1'b0;
        r_busy <= 1'b1;
      end else if (r_state == S_RUN) begin
        r_ones <= w_ones_next;
        r_cnt  <= r_cnt + {{(L-1){1'b0}}, 1'b1};
        r_d    <= w_sa;
        r_lfsr <= {r_lfsr[29:0], r_lfsr[27] ^ r_lfsr[30]};
        if (w_finish) begin
          // A full count of 2^L does not fit in W bits; clamp and flag it
          if (w_ones_next == {1'b1, {L{1'b0}}}) begin
            r_result <= '1;
            r_sat    <= 1'b1;
          end else begin
            r_result <= w_ones_next[L-1:L-W];
            r_sat    <= 1'b0;
          end
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/stoch_arith_core.md
# stoch_arith_core

Parametrised stochastic arithmetic engine: the next generation of the team's fixed 9-bit stochastic adder/multiplier. Operands are loaded in parallel under a start/done handshake rather than through serial pins and a free-running global counter. The operation is selected per run (unipolar multiply, bipolar multiply, scaled add, bipolar square), with configurable operand width and stream length. It is bit-exact against a software model because the LFSR is reseeded on every run. It sits between the serial I/O front end and the top-level pin mux.

## Interface
Parameters:
- W, 9: operand/result width; legal 2..12.
- L, 17: log2 of stream length (stream = 2^L cycles); legal W..20.
- SEED, 31'd134995: LFSR load value on reset and on every accepted start; must be nonzero.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; synchronous deassert is the integrator's job.
- start  in  1  run request, sampled only in IDLE.
- mode  in  2  00 unipolar AND multiply, 01 bipolar XNOR multiply, 10 scaled add (MUX), 11 bipolar square.
- a_in  in  W  operand A probability, value/2^W.
- b_in  in  W  operand B probability; ignored in mode 11.
- busy  out  1  high while a stream is running.
- done  out  1  one-cycle pulse; result valid and updated.
- result  out  W  quantised stream average, held until next done.
- sat  out  1  set with done when result was clamped; held with result.

## Operation
- FSM: IDLE, RUN. Reset -> IDLE; busy=0, done=0, result=0, sat=0, lfsr=SEED, counters=0, delay flop=0.
- IDLE, start=1: latch a_in, b_in, mode into a_q, b_q, m_q. Load lfsr=SEED, ones count=0, cycle count=0, delay flop=0. busy<=1. Go to RUN.
- IDLE, start=0: hold all state, including result and sat.
- RUN, each edge, using current lfsr:
  - sa = (lfsr[W-1:0] < a_q).
  - sb = (lfsr[W+11:12] < b_q).
  - sel = lfsr[30].
  - Output bit:
    - mode 00: sa & sb.
    - mode 01: ~(sa ^ sb).
    - mode 10: sel ? sb : sa.
    - mode 11: ~(sa ^ d), where d is sa registered on the previous RUN edge.
  - ones <= ones + bit; ones is L+1 bits wide so the count never wraps.
  - Then step the LFSR: lfsr <= {lfsr[29:0], lfsr[27]^lfsr[30]}. Also d <= sa.
- RUN, final edge (cycle count == 2^L-1), using ones_next (count including this edge's bit):
  - If ones_next == 2^L: result <= all ones, sat <= 1.
  - Otherwise: result <= ones_next[L-1:L-W], truncated not rounded; sat <= 0.
  - done <= 1, busy <= 0, go to IDLE.
- start while busy: ignored; no queueing, no restart.
- Operand inputs may change freely during RUN; only the latched copies are used.
- Async reset mid-run: immediate return to reset values; the partial run is discarded, result and sat clear to 0.

## Timing
- start sampled high at edge k (IDLE) -> busy=1 after edge k.
- Stream bits accumulate on edges k+1 .. k+2^L, exactly 2^L bits.
- done=1 and new result/sat visible after edge k+2^L, for exactly one cycle; busy=0 in that same cycle.
- Back-to-back: start high in the done cycle is accepted, so the next done comes 2^L+1 cycles after the previous one.
- Latency start edge -> done: 2^L cycles. Throughput: one result per 2^L+1 cycles.
- done never asserts without a preceding accepted start since the last reset.

## Test plan
All scenarios use W=8, L=10, and compare against a cycle-accurate software model seeded with SEED.
- Reset values: hold rst_n=0 -> busy=0, done=0, result=0, sat=0. Release, idle 5 cycles -> no done.
- Mode 00, a=0, b=200, start -> done exactly 1024 cycles after the start edge, result=0, sat=0. Mode 10, a=0, b=0 -> result=0.
- Mode 01, a=0, b=0 -> every bit is 1, so ones=1024, result=255, sat=1. Mode 11, a=0 -> result=255, sat=1.
- Random a, b across all 4 modes (≥50 runs, including back-to-back starts in the done cycle) -> result and sat bit-exact with the model, done period 1025 cycles.
- start pulsed repeatedly during RUN, with a_in/b_in toggling -> single done at the original time, result matches the latched operands.
- rst_n low at cycle 500 of a run -> outputs immediately 0. A new start after release -> result identical to a clean run with the same operands.
